run_checker: RTL and testbench

RUN_CHECKER -- requirements
Module: run_checker

---
 rtl/run_checker.sv | 221 ++++++++++++++++++++++
 tb/tb_run_checker.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_checker.sv
`default_nettype none
// ------------------------------------------------------------------
// run_checker : watches the fetch stream for a halt, then sweeps memory
//               comparing DUT data against an answer key.
// Revision    : 1.0
// ------------------------------------------------------------------
module run_checker #(
  parameter int WORD_WIDTH  = 32,
  parameter int ADDR_BITS   = 10,
  parameter int STALL_LIMIT = 49,
  parameter int NOP_LIMIT   = 16,
  parameter int LAST_ADDR   = 143,
  parameter int RD_LATENCY  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  restart,
  input  logic [WORD_WIDTH-1:0] inst,
  output logic                  rd_en,
  output logic [ADDR_BITS-1:0]  rd_addr,
  input  logic [WORD_WIDTH-1:0] act_data,
  input  logic [WORD_WIDTH-1:0] exp_data,
  output logic                  halted,
  output logic                  mis_valid,
  output logic [ADDR_BITS-1:0]  mis_addr,
  output logic [WORD_WIDTH-1:0] mis_act,
  output logic [WORD_WIDTH-1:0] mis_exp,
  output logic [ADDR_BITS:0]    pass_cnt,
  output logic [ADDR_BITS:0]    total_cnt,
  output logic                  check_done,
  output logic                  all_pass
);

  localparam int                    c_cnt_w     = 10;
  localparam logic [c_cnt_w-1:0]    c_stall_lim = c_cnt_w'(STALL_LIMIT);
  localparam logic [c_cnt_w-1:0]    c_nop_lim   = c_cnt_w'(NOP_LIMIT);
  localparam logic [c_cnt_w-1:0]    c_cnt_one   = c_cnt_w'(1);
  localparam logic [ADDR_BITS-1:0]  c_last      = ADDR_BITS'(LAST_ADDR);
  localparam logic [ADDR_BITS-1:0]  c_addr_one  = ADDR_BITS'(1);
  localparam logic [ADDR_BITS:0]    c_res_one   = (ADDR_BITS+1)'(1);
  localparam logic [WORD_WIDTH-1:0] c_nop32     = WORD_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {
    S_MONITOR = 2'd0,
    S_SWEEP   = 2'd1,
    S_DRAIN   = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [WORD_WIDTH-1:0]   r_last_inst;
  logic [c_cnt_w-1:0]      r_stall_cnt;
  logic [c_cnt_w-1:0]      r_nop_cnt;
  logic                    r_halted;
  logic [ADDR_BITS-1:0]    r_addr;
  logic [RD_LATENCY-1:0]   r_dv;
  logic [ADDR_BITS-1:0]    r_da [RD_LATENCY];
  logic [ADDR_BITS:0]      r_pass_cnt;
  logic [ADDR_BITS:0]      r_total_cnt;
  logic                    r_mis_valid;
  logic [ADDR_BITS-1:0]    r_mis_addr;
  logic [WORD_WIDTH-1:0]   r_mis_act;
  logic [WORD_WIDTH-1:0]   r_mis_exp;

  logic                    w_same;
  logic                    w_is_nop;
  logic [c_cnt_w-1:0]      w_stall_inc;
  logic [c_cnt_w-1:0]      w_nop_inc;
  logic                    w_halt;
  logic                    w_last_rd;
  logic                    w_pipe_empty;
  logic                    w_cmp;
  logic                    w_match;

  assign w_same       = (inst == r_last_inst);
  assign w_is_nop     = (inst[15:0] == 16'h0001) || (inst == c_nop32);
  assign w_stall_inc  = r_stall_cnt + c_cnt_one;
  assign w_nop_inc    = r_nop_cnt + c_cnt_one;
  assign w_halt       = (r_state == S_MONITOR) && en && w_same &&
                        ((w_stall_inc == c_stall_lim) ||
                         (w_is_nop && (w_nop_inc == c_nop_lim)));
  assign w_last_rd    = (r_state == S_SWEEP) && (r_addr == c_last);
  assign w_pipe_empty = ~|r_dv;
  assign w_cmp        = r_dv[RD_LATENCY-1];
  assign w_match      = (act_data == exp_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_MONITOR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    rd_en       = 1'b0;
    check_done  = 1'b0;
    all_pass    = 1'b0;
    if (restart) begin
      w_state_nxt = S_MONITOR;
    end else begin
      case (r_state)
        S_MONITOR: if (w_halt)       w_state_nxt = S_SWEEP;
        S_SWEEP:   if (w_last_rd)    w_state_nxt = S_DRAIN;
        S_DRAIN:   if (w_pipe_empty) w_state_nxt = S_FINISH;
        S_FINISH:  w_state_nxt = S_FINISH;
        default:   w_state_nxt = S_MONITOR;
      endcase
    end
    case (r_state)
      S_SWEEP:  rd_en = 1'b1;
      S_FINISH: begin
        check_done = 1'b1;
        all_pass   = (r_pass_cnt == r_total_cnt);
      end
      default: ;
    endcase
  end

  // Instruction repeat tracking; only advances while monitoring and enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_inst <= '0;
      r_stall_cnt <= '0;
      r_nop_cnt   <= '0;
    end else if (restart) begin
      r_last_inst <= '0;
      r_stall_cnt <= '0;
      r_nop_cnt   <= '0;
    end else if ((r_state == S_MONITOR) && en) begin
      if (w_same) begin
        r_stall_cnt <= w_stall_inc;
        if (w_is_nop) begin
          r_nop_cnt <= w_nop_inc;
        end
      end else begin
        r_last_inst <= inst;
        r_stall_cnt <= '0;
        r_nop_cnt   <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halted <= 1'b0;
      r_addr   <= '0;
    end else if (restart) begin
      r_halted <= 1'b0;
    end else if (w_halt) begin
      r_halted <= 1'b1;
      r_addr   <= '0;
    end else if ((r_state == S_SWEEP) && !w_last_rd) begin
      r_addr <= r_addr + c_addr_one;
    end
  end

  // Read-valid/address delay line aligned with the memory read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dv <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_da[i] <= '0;
      end
    end else if (restart) begin
      r_dv <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_da[i] <= '0;
      end
    end else begin
      for (int i = RD_LATENCY-1; i > 0; i--) begin
        r_dv[i] <= r_dv[i-1];
        r_da[i] <= r_da[i-1];
      end
      r_dv[0] <= rd_en;
      r_da[0] <= r_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pass_cnt  <= '0;
      r_total_cnt <= '0;
      r_mis_valid <= 1'b0;
      r_mis_addr  <= '0;
      r_mis_act   <= '0;
      r_mis_exp   <= '0;
    end else if (restart) begin
      r_pass_cnt  <= '0;
      r_total_cnt <= '0;
      r_mis_valid <= 1'b0;
    end else begin
      r_mis_valid <= w_cmp && !w_match;
      if (w_cmp) begin
        r_total_cnt <= r_total_cnt + c_res_one;
        if (w_match) begin
          r_pass_cnt <= r_pass_cnt + c_res_one;
        end else begin
          r_mis_addr <= r_da[RD_LATENCY-1];
          r_mis_act  <= act_data;
          r_mis_exp  <= exp_data;
        end
      end
    end
  end

  assign rd_addr   = r_addr;
  assign halted    = r_halted;
  assign mis_valid = r_mis_valid;
  assign mis_addr  = r_mis_addr;
  assign mis_act   = r_mis_act;
  assign mis_exp   = r_mis_exp;
  assign pass_cnt  = r_pass_cnt;
  assign total_cnt = r_total_cnt;

endmodule
`default_nettype wire

// File: tb/tb_run_checker.sv
`default_nettype none
// tb_run_checker : scoreboard bench; mismatches are queued when the read is
// issued and popped when mis_valid fires.
module tb_run_checker;

  localparam int WW = 32, AB = 10, STL = 4, NPL = 2, LAST = 3, LAT = 2;

  logic          clk = 1'b0, rst = 1'b0, en = 1'b0, restart = 1'b0;
  logic [WW-1:0] inst = '0;
  logic          rd_en, halted, mis_valid, check_done, all_pass;
  logic [AB-1:0] rd_addr, mis_addr;
  logic [WW-1:0] act_data, exp_data, mis_act, mis_exp;
  logic [AB:0]   pass_cnt, total_cnt;

  int checks = 0, errors = 0, mis_seen = 0;

  logic [WW-1:0] act_mem [0:LAST];
  logic [WW-1:0] exp_mem [0:LAST];

  typedef struct packed {
    logic [AB-1:0] addr;
    logic [WW-1:0] act;
    logic [WW-1:0] exp;
  } mis_t;
  mis_t sb_q[$];

  logic          p1_v = 1'b0, p2_v = 1'b0;
  logic [AB-1:0] p1_a = '0, p2_a = '0;

  run_checker #(
    .WORD_WIDTH(WW), .ADDR_BITS(AB), .STALL_LIMIT(STL),
    .NOP_LIMIT(NPL), .LAST_ADDR(LAST), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .inst(inst),
    .rd_en(rd_en), .rd_addr(rd_addr), .act_data(act_data), .exp_data(exp_data),
    .halted(halted), .mis_valid(mis_valid), .mis_addr(mis_addr),
    .mis_act(mis_act), .mis_exp(mis_exp), .pass_cnt(pass_cnt),
    .total_cnt(total_cnt), .check_done(check_done), .all_pass(all_pass)
  );

  always #5 clk = ~clk;

  // Two-cycle read memory model
  always @(posedge clk) begin
    p1_v <= rd_en;
    p1_a <= rd_addr;
    p2_v <= p1_v;
    p2_a <= p1_a;
  end
  assign act_data = p2_v ? act_mem[p2_a[1:0]] : '0;
  assign exp_data = p2_v ? exp_mem[p2_a[1:0]] : '0;

  always @(posedge clk) begin
    mis_t e;
    if (!rst && rd_en && (act_mem[rd_addr[1:0]] !== exp_mem[rd_addr[1:0]])) begin
      e.addr = rd_addr;
      e.act  = act_mem[rd_addr[1:0]];
      e.exp  = exp_mem[rd_addr[1:0]];
      sb_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    mis_t e;
    if (mis_valid === 1'b1) begin
      mis_seen++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_mis: mis_valid=1 addr=%0d with empty scoreboard", mis_addr);
      end else begin
        e = sb_q.pop_front();
        if (mis_addr !== e.addr || mis_act !== e.act || mis_exp !== e.exp) begin
          errors++;
          $display("FAIL mis_details: got addr=%0d act=%h exp=%h want addr=%0d act=%h exp=%h",
                   mis_addr, mis_act, mis_exp, e.addr, e.act, e.exp);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart;
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic wait_finish(input string tag);
    int n = 0;
    while (check_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (check_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: check_done=%b want 1", tag, check_done);
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    checks++; if (rd_en !== 1'b0)      begin errors++; $display("FAIL rst_rd_en: got %b want 0", rd_en); end
    checks++; if (rd_addr !== '0)      begin errors++; $display("FAIL rst_rd_addr: got %0d want 0", rd_addr); end
    checks++; if (halted !== 1'b0)     begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
    checks++; if (mis_valid !== 1'b0)  begin errors++; $display("FAIL rst_mis_valid: got %b want 0", mis_valid); end
    checks++; if (pass_cnt !== '0 || total_cnt !== '0) begin
      errors++; $display("FAIL rst_counts: got pass=%0d total=%0d want 0/0", pass_cnt, total_cnt); end
    checks++; if (check_done !== 1'b0 || all_pass !== 1'b0) begin
      errors++; $display("FAIL rst_done: got done=%b all_pass=%b want 0/0", check_done, all_pass); end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_nop_halt;
    en = 1'b1;
    inst = 32'h0000_0013;
    tick();
    tick();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL nop_early: halted=%b want 0 after edge 2", halted); end
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL nop_halt: halted=%b want 1 after edge 3", halted); end
    en = 1'b0;
    for (int k = 0; k <= LAST; k++) begin
      checks++;
      if (rd_en !== 1'b1 || rd_addr !== AB'(k)) begin
        errors++; $display("FAIL sweep_addr: got rd_en=%b addr=%0d want 1/%0d", rd_en, rd_addr, k);
      end
      tick();
    end
    checks++; if (rd_en !== 1'b0 || rd_addr !== AB'(LAST)) begin
      errors++; $display("FAIL drain_rd: got rd_en=%b addr=%0d want 0/%0d", rd_en, rd_addr, LAST); end
    wait_finish("allmatch");
    repeat (3) tick();
    checks++; if (pass_cnt !== 11'd4 || total_cnt !== 11'd4) begin
      errors++; $display("FAIL allmatch_counts: got pass=%0d total=%0d want 4/4", pass_cnt, total_cnt); end
    checks++; if (all_pass !== 1'b1 || halted !== 1'b1) begin
      errors++; $display("FAIL allmatch_pass: got all_pass=%b halted=%b want 1/1", all_pass, halted); end
    checks++; if (mis_seen != 0) begin errors++; $display("FAIL allmatch_mis: got %0d pulses want 0", mis_seen); end
  endtask

  task automatic test_stall_halt;
    do_restart();
    checks++; if (halted !== 1'b0 || check_done !== 1'b0 || total_cnt !== '0 || pass_cnt !== '0) begin
      errors++; $display("FAIL restart_clear: got halted=%b done=%b total=%0d pass=%0d want 0/0/0/0",
                         halted, check_done, total_cnt, pass_cnt); end
    en = 1'b1;
    inst = 32'h00A0_0093;
    repeat (4) tick();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL stall_early: halted=%b want 0 after edge 4", halted); end
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL stall_halt: halted=%b want 1 after edge 5", halted); end
    en = 1'b0;
    wait_finish("stall");
    do_restart();
    en = 1'b1;
    tick();
    tick();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    tick();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL stall_en_early: halted=%b want 0 after edge 5", halted); end
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL stall_en_halt: halted=%b want 1 after edge 6", halted); end
    en = 1'b0;
    wait_finish("stall_en");
    checks++; if (total_cnt !== 11'd4) begin errors++; $display("FAIL stall_total: got %0d want 4", total_cnt); end
  endtask

  task automatic test_mismatch;
    int mis0;
    do_restart();
    act_mem[2] = 32'hDEAD_BEEF;
    exp_mem[2] = 32'h0000_0005;
    mis0 = mis_seen;
    en = 1'b1;
    inst = 32'h0000_0013;
    repeat (3) tick();
    en = 1'b0;
    wait_finish("mismatch");
    tick();
    checks++; if (pass_cnt !== 11'd3 || total_cnt !== 11'd4) begin
      errors++; $display("FAIL mismatch_counts: got pass=%0d total=%0d want 3/4", pass_cnt, total_cnt); end
    checks++; if (all_pass !== 1'b0) begin errors++; $display("FAIL mismatch_all_pass: got %b want 0", all_pass); end
    checks++; if (mis_seen - mis0 != 1 || sb_q.size() != 0) begin
      errors++; $display("FAIL mismatch_pulses: got %0d pulses, %0d pending want 1/0", mis_seen - mis0, sb_q.size()); end
    act_mem[2] = exp_mem[2];
  endtask

  task automatic test_restart_drain;
    int mis0;
    int n = 0;
    do_restart();
    act_mem[3] = 32'hBAD0_0003;
    mis0 = mis_seen;
    en = 1'b1;
    inst = 32'h0000_0013;
    repeat (3) tick();
    en = 1'b0;
    while (!(rd_en === 1'b1 && rd_addr === AB'(LAST)) && n < 20) begin
      tick();
      n++;
    end
    tick();
    checks++; if (rd_en !== 1'b0 || total_cnt !== 11'd2) begin
      errors++; $display("FAIL drain_entry: got rd_en=%b total=%0d want 0/2", rd_en, total_cnt); end
    do_restart();
    sb_q.delete();
    checks++; if (halted !== 1'b0 || total_cnt !== '0 || pass_cnt !== '0 || check_done !== 1'b0) begin
      errors++; $display("FAIL drain_restart: got halted=%b total=%0d pass=%0d done=%b want 0/0/0/0",
                         halted, total_cnt, pass_cnt, check_done); end
    repeat (6) tick();
    checks++; if (mis_seen != mis0 || total_cnt !== '0 || check_done !== 1'b0) begin
      errors++; $display("FAIL drain_discard: got pulses=%0d total=%0d done=%b want 0/0/0",
                         mis_seen - mis0, total_cnt, check_done); end
    act_mem[3] = exp_mem[3];
  endtask

  task automatic test_restart_halt_same_edge;
    en = 1'b1;
    inst = 32'h0000_0013;
    tick();
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    en = 1'b0;
    checks++; if (halted !== 1'b0 || rd_en !== 1'b0) begin
      errors++; $display("FAIL restart_priority: got halted=%b rd_en=%b want 0/0", halted, rd_en); end
    tick();
    checks++; if (halted !== 1'b0 || rd_en !== 1'b0) begin
      errors++; $display("FAIL restart_stay: got halted=%b rd_en=%b want 0/0", halted, rd_en); end
  endtask

  task automatic test_rst_mid_sweep;
    int mis0;
    act_mem[3] = 32'hBAD0_0003;
    mis0 = mis_seen;
    en = 1'b1;
    inst = 32'h0000_0013;
    repeat (3) tick();
    en = 1'b0;
    tick();
    checks++; if (halted !== 1'b1 || rd_en !== 1'b1 || rd_addr !== AB'(1)) begin
      errors++; $display("FAIL pre_rst_sweep: got halted=%b rd_en=%b addr=%0d want 1/1/1", halted, rd_en, rd_addr); end
    #2 rst = 1'b1;
    #1;
    checks++; if (halted !== 1'b0 || rd_en !== 1'b0 || rd_addr !== '0) begin
      errors++; $display("FAIL async_rst_ctl: got halted=%b rd_en=%b addr=%0d want 0/0/0", halted, rd_en, rd_addr); end
    checks++; if (mis_addr !== '0 || mis_act !== '0 || mis_exp !== '0 || mis_valid !== 1'b0) begin
      errors++; $display("FAIL async_rst_mis: got v=%b addr=%0d act=%h exp=%h want all 0",
                         mis_valid, mis_addr, mis_act, mis_exp); end
    checks++; if (pass_cnt !== '0 || total_cnt !== '0) begin
      errors++; $display("FAIL async_rst_cnt: got pass=%0d total=%0d want 0/0", pass_cnt, total_cnt); end
    rst = 1'b0;
    sb_q.delete();
    repeat (6) tick();
    checks++; if (mis_seen != mis0 || total_cnt !== '0) begin
      errors++; $display("FAIL rst_abort: got pulses=%0d total=%0d want 0/0", mis_seen - mis0, total_cnt); end
    act_mem[3] = exp_mem[3];
    en = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL rehalt: halted=%b want 1", halted); end
    wait_finish("resweep");
    tick();
    checks++; if (pass_cnt !== 11'd4 || total_cnt !== 11'd4 || all_pass !== 1'b1) begin
      errors++; $display("FAIL resweep_result: got pass=%0d total=%0d all_pass=%b want 4/4/1",
                         pass_cnt, total_cnt, all_pass); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i <= LAST; i++) begin
      act_mem[i] = 32'h1000_0000 + i;
      exp_mem[i] = 32'h1000_0000 + i;
    end
    test_reset();
    test_nop_halt();
    test_stall_halt();
    test_mismatch();
    test_restart_drain();
    test_restart_halt_same_edge();
    test_rst_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
